pipe_mux_stage: RTL and testbench
=================================

Name: pipe_mux_stage

Overview:
- Parametrised N:1 operand multiplexer with a registered, flow-controlled output stage.
- Generalises the fixed 2- and 3-input datapath muxes to any width, input count and select encoding.
- Adds a valid/ready handshake with a two-entry skid buffer, so the forwarding and write-back select paths can sit between pipeline stages that stall independently.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of data inputs (2..16).
- ONEHOT, 0: 0 = binary select, 1 = one-hot select.
- OOR_VALUE, 0, WIDTH-bit value driven when the select is invalid.
- SEL_W, derived: NUM_IN if ONEHOT=1, else max(1, clog2(NUM_IN)). Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; same effect as reset on the stage contents.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select, binary or one-hot per ONEHOT.
- in_valid  in  1  upstream presents data and select.
- in_ready  out  1  stage can accept; registered.
- out_data  out  WIDTH  selected value.
- out_sel_err  out  1  the entry in out_data came from an invalid select.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Select decode (combinational, at input):
  - Binary mode: in_sel < NUM_IN selects input in_sel. in_sel >= NUM_IN gives OOR_VALUE with err=1.
  - One-hot mode: exactly one bit set selects that input. Zero bits set, or more than one bit set, gives OOR_VALUE with err=1.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_sel_err stay stable while out_valid && !out_ready.
- Storage: a main register (drives the outputs) and a skid register. Each stores {data, err}.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- Transitions:
  - EMPTY: accepts input -> ONE. Latency is 1 cycle from acceptance to out_valid.
  - ONE:
    - accept and output transfer -> ONE, main loads the new entry.
    - accept only -> FULL, new entry goes to skid.
    - output transfer only -> EMPTY.
  - FULL:
    - in_ready=0.
    - output transfer -> ONE, skid moves to main.
    - otherwise hold.
- in_ready: registered; 1 in EMPTY and ONE, 0 in FULL. It is never combinationally dependent on out_ready.
- Ordering: strict FIFO order; no entry is dropped or duplicated.
- Reset values: out_valid=0, out_data=0, out_sel_err=0, in_ready=1, state EMPTY.
- Flush:
  - Next state is EMPTY, with the same output values as reset.
  - Any input presented in the flush cycle is discarded, even if in_valid && in_ready.
  - An output transfer in the flush cycle still counts downstream.
  - in_ready=1 on the following cycle.
- reset and flush together: reset semantics.
- Reset mid-stall (FULL): both entries are lost; outputs go to reset values on the next edge.
- NUM_IN not a power of two in binary mode: the unused codes are out of range and handled as above.

Decomposition:
- Shared package mux_pkg holds:
  - MUX_MODE_BINARY=0 and MUX_MODE_ONEHOT=1 constants.
  - a function computing SEL_W from NUM_IN and mode.
  - the state encoding localparams EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One sub-module, mux_select_comb: purely combinational N:1 decode producing {data, err}. It is instantiated once at the stage input.
- pipe_mux_stage owns the skid buffer and the state machine.

Test Plan:
- Reset behaviour: WIDTH=32, NUM_IN=3, binary. Assert reset 2 cycles, then drive inputs {0x11,0x22,0x33}, in_sel=2, in_valid=1, out_ready=1 -> one cycle later out_valid=1, out_data=0x33, out_sel_err=0.
- Out-of-range select: binary, NUM_IN=3, in_sel=3 -> out_data=0x00000000 (OOR_VALUE), out_sel_err=1. Repeat with OOR_VALUE=0xDEADBEEF -> out_data=0xDEADBEEF.
- One-hot mode: NUM_IN=4, in_sel=4'b0100 -> input 2. in_sel=4'b0110 -> OOR_VALUE with err=1. in_sel=4'b0000 -> err=1.
- Backpressure: stream sel=0,1,2 with out_ready=0.
  - After two accepts, in_ready=0 and out_data holds the first value, stable for 5 cycles.
  - Raise out_ready -> all three values emerge in order, with no loss or duplicates.
- Flush in FULL: while FULL, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed input never appears at the output.
- Throughput: continuous in_valid and out_ready for 100 random selects -> one output per cycle after a 1-cycle latency. Output sequence matches a reference model; in_ready stays at 1 throughout.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, select-width helper and stage state encoding.
package mux_pkg;

    localparam int MUX_MODE_BINARY = 0;
    localparam int MUX_MODE_ONEHOT = 1;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    function automatic int sel_width(input int num_in, input int mode);
        return (mode == MUX_MODE_ONEHOT) ? num_in : (num_in > 2 ? $clog2(num_in) : 1);
    endfunction

endpackage

// File: rtl/mux_select_comb.sv
// mux_select_comb: combinational N:1 select decode producing {data, err}.
module mux_select_comb
    import mux_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              NUM_IN    = 3,
    parameter int              ONEHOT    = 0,
    parameter logic [WIDTH-1:0] OOR_VALUE = '0,
    localparam int             SEL_W     = sel_width(NUM_IN, ONEHOT)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  picked;

    // Both encodings reduce to a per-input hit vector; a legal select hits exactly one input.
    generate
        if (ONEHOT == MUX_MODE_ONEHOT) begin : g_onehot
            assign hit = sel;
        end else begin : g_binary
            for (genvar i = 0; i < NUM_IN; i++) begin : g_hit
                assign hit[i] = sel == SEL_W'(i);
            end
        end
    endgenerate

    always_comb begin
        picked = '0;
        for (int k = 0; k < NUM_IN; k++)
            picked = picked | (hit[k] ? in_data[k*WIDTH +: WIDTH] : '0);
    end

    assign err  = !$onehot(hit);
    assign data = err ? OOR_VALUE : picked;

endmodule

// File: rtl/pipe_mux_stage.sv
// pipe_mux_stage: N:1 operand mux with a registered valid/ready output stage
// and a two-entry skid buffer so in_ready never depends on out_ready.
module pipe_mux_stage
    import mux_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              NUM_IN    = 3,
    parameter int              ONEHOT    = 0,
    parameter logic [WIDTH-1:0] OOR_VALUE = '0,
    localparam int             SEL_W     = sel_width(NUM_IN, ONEHOT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] dec_data, main_data, skid_data;
    logic             dec_err, main_err, skid_err, ready_q;
    logic             acc, xfer, load_in, load_skid, skid_to_main;

    mux_select_comb #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .ONEHOT    (ONEHOT),
        .OOR_VALUE (OOR_VALUE)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (dec_data),
        .err     (dec_err)
    );

    // Input presented during a flush is dropped, so it never counts as accepted.
    assign acc  = in_valid && ready_q && !flush;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= state_nx != FULL;
            if (load_in)
                {main_data, main_err} <= {dec_data, dec_err};
            else if (skid_to_main)
                {main_data, main_err} <= {skid_data, skid_err};
            if (load_skid)
                {skid_data, skid_err} <= {dec_data, dec_err};
        end
    end

    always_comb begin
        state_nx     = flush          ? EMPTY :
                       state == EMPTY ? (acc ? ONE : EMPTY) :
                       state == ONE   ? (acc == xfer ? ONE : (acc ? FULL : EMPTY)) :
                                        (xfer ? ONE : FULL);
        load_in      = acc && (state == EMPTY || xfer);
        load_skid    = acc && state == ONE && !xfer;
        skid_to_main = state == FULL && xfer;
    end

    always_comb begin
        out_valid   = state != EMPTY;
        out_data    = main_data;
        out_sel_err = main_err;
        in_ready    = ready_q;
    end

endmodule

// File: tb/tb_pipe_mux_stage.sv
// tb_pipe_mux_stage: scoreboard bench over binary, binary-OOR and one-hot instances.
module tb_pipe_mux_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [1:0]  sel_b;
    logic [3:0]  sel_h;
    logic [31:0] w [4];
    logic        ir [3];
    logic        ov [3];
    logic        oe [3];
    logic [31:0] od [3];
    logic [32:0] q [3][$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0), .OOR_VALUE(32'h0)) dut_bin (
        .clk(clk), .reset(reset), .flush(flush), .in_data({w[2], w[1], w[0]}), .in_sel(sel_b),
        .in_valid(in_valid), .in_ready(ir[0]), .out_data(od[0]), .out_sel_err(oe[0]),
        .out_valid(ov[0]), .out_ready(out_ready));

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0), .OOR_VALUE(32'hDEADBEEF)) dut_dead (
        .clk(clk), .reset(reset), .flush(flush), .in_data({w[2], w[1], w[0]}), .in_sel(sel_b),
        .in_valid(in_valid), .in_ready(ir[1]), .out_data(od[1]), .out_sel_err(oe[1]),
        .out_valid(ov[1]), .out_ready(out_ready));

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(4), .ONEHOT(1), .OOR_VALUE(32'h0)) dut_oh (
        .clk(clk), .reset(reset), .flush(flush), .in_data({w[3], w[2], w[1], w[0]}), .in_sel(sel_h),
        .in_valid(in_valid), .in_ready(ir[2]), .out_data(od[2]), .out_sel_err(oe[2]),
        .out_valid(ov[2]), .out_ready(out_ready));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input int i);
        if (i < 2)
            return (sel_b < 2'd3) ? {1'b0, w[sel_b]} : {1'b1, (i == 0) ? 32'h0 : 32'hDEADBEEF};
        return ($countones(sel_h) == 1) ? {1'b0, w[$clog2(sel_h)]} : {1'b1, 32'h0};
    endfunction

    // Scoreboard: pop on output transfer, push the model value on input transfer.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) q[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && out_ready) begin
                    if (q[i].size() == 0)
                        check($sformatf("spurious_out%0d", i), 64'(q[i].size()), 64'd1);
                    else
                        check($sformatf("out%0d", i), {31'd0, oe[i], od[i]}, {31'd0, q[i].pop_front()});
                end
                if (flush)
                    q[i].delete();
                else if (in_valid && ir[i])
                    q[i].push_back(model(i));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 20) begin
            step();
            n++;
        end
        check(tag, 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        sel_b = 2'd2; sel_h = 4'b0100;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", 64'(ov[i]), 64'd0);
            check("rst_data", 64'(od[i]), 64'd0);
            check("rst_err", 64'(oe[i]), 64'd0);
            check("rst_ready", 64'(ir[i]), 64'd1);
        end
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_valid", 64'(ov[0]), 64'd1);
        check("lat_data", 64'(od[0]), 64'h33);
        check("lat_err", 64'(oe[0]), 64'd0);
        check("oh_data", 64'(od[2]), 64'h33);
        step();
        check("lat_empty", 64'(ov[0]), 64'd0);

        in_valid = 1'b1; sel_b = 2'd3; sel_h = 4'b0110;
        step();
        check("oor_data", 64'(od[0]), 64'h0);
        check("oor_err", 64'(oe[0]), 64'd1);
        check("oor_dead", 64'(od[1]), 64'hDEADBEEF);
        check("oh_multi_err", 64'(oe[2]), 64'd1);
        sel_h = 4'b0000;
        step();
        check("oh_zero_err", 64'(oe[2]), 64'd1);
        sel_b = 2'd1; sel_h = 4'b1000;
        step();
        check("oh_bit3", 64'(od[2]), 64'h44);
        in_valid = 1'b0;
        drain("oor_drain");

        out_ready = 1'b0; in_valid = 1'b1; sel_b = 2'd0; sel_h = 4'b0001;
        step();
        sel_b = 2'd1; sel_h = 4'b0010;
        step();
        sel_b = 2'd2; sel_h = 4'b0100;
        check("bp_ready", 64'(ir[0]), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", 64'(od[0]), 64'h11);
            check("bp_valid", 64'(ov[0]), 64'd1);
        end
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        drain("bp_drain");

        out_ready = 1'b0; in_valid = 1'b1; sel_b = 2'd0;
        step();
        sel_b = 2'd1;
        step();
        check("fl_full", 64'(ir[0]), 64'd0);
        flush = 1'b1; sel_b = 2'd2;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(ov[0]), 64'd0);
        check("fl_ready", 64'(ir[0]), 64'd1);
        check("fl_data", 64'(od[0]), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_quiet", 64'(ov[0]), 64'd0);

        out_ready = 1'b0; in_valid = 1'b1; sel_b = 2'd2;
        repeat (2) step();
        reset = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 64'(ov[0]), 64'd0);
        check("mid_rst_data", 64'(od[0]), 64'd0);
        check("mid_rst_ready", 64'(ir[0]), 64'd1);

        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            for (int j = 0; j < 4; j++) w[j] = $urandom;
            sel_b = 2'($urandom_range(0, 3));
            sel_h = 4'($urandom_range(0, 15));
            step();
            check("tp_ready", 64'(ir[0]), 64'd1);
            check("tp_valid", 64'(ov[0]), 64'd1);
        end
        in_valid = 1'b0;
        drain("tp_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
